// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES byte/state types and forward/inverse S-box constants
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0][3:0] state_t;

    // Ascending range so that SBOX[i] is the i-th byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - single-byte inverse S-box lookup
import aes_pkg::*;

module inv_sbox (
    input  byte_t data_in,
    output byte_t data_out
);

    // Plain constant ROM lookup; no arithmetic inverse.
    assign data_out = INV_SBOX[data_in];

endmodule

// File: rtl/reverse_substitute_key.sv
// rtl/reverse_substitute_key.sv - InvSubBytes over a 4x4 array; REVERSE_SUBKEY_COMB_OUT_EN selects zero-latency output
import aes_pkg::*;

module reverse_substitute_key (
    input  logic   clk,
    input  logic   reset,
    input  logic   in_valid,
    input  state_t subkeyin,
    output logic   out_valid,
    output state_t subkeyout
);

    state_t sub_bytes;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            inv_sbox u_inv_sbox (
                .data_in  (subkeyin[r][c]),
                .data_out (sub_bytes[r][c])
            );
        end
    end

`ifdef REVERSE_SUBKEY_COMB_OUT_EN
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    assign subkeyout = sub_bytes;
    assign out_valid = in_valid;
`else
    // Capture the substituted array on valid; otherwise hold data and drop valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            subkeyout <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                subkeyout <= sub_bytes;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reverse_substitute_key.sv
// tb/tb_reverse_substitute_key.sv - self-checking bench for reverse_substitute_key
import aes_pkg::*;

module tb_reverse_substitute_key;

    logic   clk = 1'b0;
    logic   reset = 1'b0;
    logic   in_valid = 1'b0;
    state_t subkeyin = '0;
    logic   out_valid;
    state_t subkeyout;

    int tests = 0;
    int fails = 0;

    state_t exp_q[$];
    state_t last_out = '0;

    typedef struct {
        string  name;
        state_t din;
        state_t dexp;
    } vec_t;

    vec_t vecs[$];

    reverse_substitute_key dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .subkeyin  (subkeyin),
        .out_valid (out_valid),
        .subkeyout (subkeyout)
    );

    always #5 clk = ~clk;

    // Independent model: invert the forward S-box by search.
    function automatic byte_t inv_model(input byte_t b);
        byte_t res = 8'h00;
        for (int i = 0; i < 256; i++) begin
            if (SBOX[i] == b) res = byte_t'(i);
        end
        return res;
    endfunction

    function automatic state_t fill(input byte_t b);
        state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = b;
        return s;
    endfunction

    task automatic check(input string name, input logic v_got, input logic v_exp,
                         input state_t d_got, input state_t d_exp);
        tests++;
        if (v_got !== v_exp || d_got !== d_exp) begin
            fails++;
            $display("FAIL %s: got valid=%0b data=%h, want valid=%0b data=%h",
                     name, v_got, d_got, v_exp, d_exp);
        end
    endtask

    task automatic check_out(input string name, input logic v);
        state_t e;
        if (v) begin
            e = exp_q.pop_front();
            check(name, out_valid, 1'b1, subkeyout, e);
            last_out = e;
        end else begin
`ifdef REVERSE_SUBKEY_COMB_OUT_EN
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s: got valid=%0b, want valid=0", name, out_valid);
            end
`else
            check(name, out_valid, 1'b0, subkeyout, last_out);
`endif
        end
    endtask

    // Drive one array at the falling edge and check the result at its due time.
    task automatic step(input string name, input state_t d, input logic v, input state_t e);
        @(negedge clk);
        subkeyin = d;
        in_valid = v;
        if (v) exp_q.push_back(e);
`ifdef REVERSE_SUBKEY_COMB_OUT_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
        check_out(name, v);
    endtask

    initial begin
        state_t d, e;

        // Reference vectors: single bytes over a 0x63 background (maps to 0x00) and whole arrays.
        d = fill(8'h63); e = '0; d[3][3] = 8'hc9; e[3][3] = 8'h12;
        vecs.push_back('{"byte33_c9", d, e});
        d = fill(8'h63); e = '0; d[2][2] = 8'hda; e[2][2] = 8'h7a;
        vecs.push_back('{"byte22_da", d, e});
        d = fill(8'h63); e = '0; d[1][1] = 8'hd7; e[1][1] = 8'h0d;
        vecs.push_back('{"byte11_d7", d, e});
        d = fill(8'h63); e = '0; d[0][0] = 8'h6a; e[0][0] = 8'h58;
        vecs.push_back('{"byte00_6a", d, e});
        vecs.push_back('{"all_63", fill(8'h63), fill(8'h00)});
        vecs.push_back('{"all_00", fill(8'h00), fill(8'h52)});
        vecs.push_back('{"all_ff", fill(8'hff), fill(8'h7d)});

`ifndef REVERSE_SUBKEY_COMB_OUT_EN
        // Asynchronous reset between edges takes effect immediately.
        #3;
        reset = 1'b1;
        #1;
        check("reset_async", out_valid, 1'b0, subkeyout, '0);
        in_valid = 1'b1;
        subkeyin = fill(8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", out_valid, 1'b0, subkeyout, '0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release_idle", out_valid, 1'b0, subkeyout, '0);
        last_out = '0;
`endif

        // Table vectors applied back-to-back.
        foreach (vecs[i]) step(vecs[i].name, vecs[i].din, 1'b1, vecs[i].dexp);

        // Valid drop: data holds, X on the input is ignored.
        step("idle_hold", fill(8'h12), 1'b0, '0);
        step("idle_x_input", 'x, 1'b0, '0);

        // Exhaustive: every value at every position, others at 0x63.
        for (int p = 0; p < 16; p++) begin
            for (int v = 0; v < 256; v++) begin
                d = fill(8'h63);
                e = '0;
                d[p / 4][p % 4] = byte_t'(v);
                e[p / 4][p % 4] = inv_model(byte_t'(v));
                step("exhaustive", d, 1'b1, e);
            end
        end
        step("post_exhaustive_hold", fill(8'h00), 1'b0, '0);

`ifndef REVERSE_SUBKEY_COMB_OUT_EN
        // Reset mid-stream discards the pending array; next capture is correct.
        step("pre_reset_data", fill(8'hc9), 1'b1, fill(8'h12));
        @(negedge clk);
        subkeyin = fill(8'hda);
        in_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midstream_reset_async", out_valid, 1'b0, subkeyout, '0);
        @(posedge clk);
        #1;
        check("midstream_reset_edge", out_valid, 1'b0, subkeyout, '0);
        @(negedge clk);
        reset = 1'b0;
        subkeyin = fill(8'hd7);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", out_valid, 1'b1, subkeyout, fill(8'h0d));
        last_out = fill(8'h0d);
        step("after_reset_idle", fill(8'h6a), 1'b0, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
